// File: rtl/fetch_pkg.sv
// Shared types and constants for the program-counter / fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } fetch_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE         = 2'd0,
    CAUSE_MISALIGNED   = 2'd1,
    CAUSE_OUT_OF_RANGE = 2'd2
  } fault_cause_t;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux (jump > branch > sequential) with fetch-target trap detection.
module pc_next_sel
  import fetch_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 128
) (
  input  logic [31:0] pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_taken,
  input  logic [31:0] jump_target,
  output logic [31:0] next_pc,
  output logic        trap,
  output logic [1:0]  cause
);

  // Compare in 33 bits so the byte limit itself can never overflow.
  localparam logic [32:0] LIMIT = 33'(IMEM_WORDS) * 33'd4;

  always_comb begin
    next_pc = pc + 32'd4;
    trap    = 1'b0;
    cause   = CAUSE_NONE;
    if (jump_taken) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end
    if (next_pc[1:0] != 2'b00) begin
      trap  = 1'b1;
      cause = CAUSE_MISALIGNED;
    end else if ({1'b0, next_pc} >= LIMIT) begin
      trap  = 1'b1;
      cause = CAUSE_OUT_OF_RANGE;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter, fetch FSM and trap bookkeeping; drives instraddr into InstructionMem.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS   = 128,
  parameter logic [31:0] NOP_INSTR    = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_taken,
  input  logic [31:0] jump_target,
  input  logic        halt_req,
  output logic [31:0] instraddr,
  input  logic [31:0] instruction,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_count
);

  fetch_state_t state_q, state_d;
  fault_cause_t cause_q, cause_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  fault_pc_q, fault_pc_d;
  logic [31:0]  count_q, count_d;
  logic         fault_q, fault_d;

  logic [31:0]  sel_pc;
  logic         sel_trap;
  logic [1:0]   sel_cause;

  pc_next_sel #(
    .IMEM_WORDS (IMEM_WORDS)
  ) u_next_sel (
    .pc            (pc_q),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump_taken    (jump_taken),
    .jump_target   (jump_target),
    .next_pc       (sel_pc),
    .trap          (sel_trap),
    .cause         (sel_cause)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      fault_q    <= 1'b0;
      cause_q    <= CAUSE_NONE;
      fault_pc_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_q    <= fault_d;
      cause_q    <= cause_d;
      fault_pc_q <= fault_pc_d;
      count_q    <= count_d;
    end
  end

  // The instruction at pc is accepted in any unstalled RUN cycle, including
  // the one that traps or halts; only the PC update is suppressed then.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_d    = fault_q;
    cause_d    = cause_q;
    fault_pc_d = fault_pc_q;
    count_d    = count_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (!stall) begin
          count_d = count_q + 32'd1;
          if (sel_trap) begin
            state_d    = FAULT;
            fault_d    = 1'b1;
            cause_d    = fault_cause_t'(sel_cause);
            fault_pc_d = pc_q;
          end else if (halt_req) begin
            state_d = HALTED;
          end else begin
            pc_d = sel_pc;
          end
        end
      end
      HALTED: state_d = HALTED;
      FAULT:  state_d = FAULT;
      default: state_d = BOOT;
    endcase
  end

  assign instraddr   = pc_q;
  assign pc_out      = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign instr_valid = (state_q == RUN);
  assign instr_out   = instr_valid ? instruction : NOP_INSTR;
  assign fault       = fault_q;
  assign fault_cause = cause_q;
  assign fault_pc    = fault_pc_q;
  assign fetch_count = count_q;

endmodule
